// File: rtl/snax_alu_out_buffer_if.sv
// Valid/ready stream bundle used on both sides of the SNAX ALU output buffer.
interface snax_alu_out_buffer_if #(
  parameter int unsigned Width = 128
) ();
  logic [Width-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/snax_alu_out_buffer.sv
// SNAX ALU output buffer: FIFO between PE results and the streamer write port, with job counting.
// Optional feature macro: SNAX_ALU_OUT_PREFIX_SUM_EN (stores a running sum of the job's results).
module snax_alu_out_buffer #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned Depth     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [31:0]                  num_elem_i,
  snax_alu_out_buffer_if.slave         c,
  output logic                         acc_ready_o,
  snax_alu_out_buffer_if.master        out,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [31:0]                  count_o
);
  localparam int unsigned OutWidth = 2 * DataWidth;
  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam int unsigned CntWidth = PtrWidth + 1;

  typedef enum logic [1:0] {Idle, Run, Drain} state_e;

  state_e               state_q, state_d;
  logic                 done_q, done_d;
  logic                 start_job;
  logic [31:0]          target_q, count_q;
  logic [CntWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OutWidth-1:0]  mem_q [Depth];
  logic [OutWidth-1:0]  wr_data;
  logic                 full, empty, c_ready_c, push, pop;

  // Pointer MSB is the wrap bit distinguishing full from empty.
  assign full  = (wr_ptr_q[PtrWidth] != rd_ptr_q[PtrWidth]) &&
                 (wr_ptr_q[PtrWidth-1:0] == rd_ptr_q[PtrWidth-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Ready depends on registered state only, so the PE may derive valid from it.
  assign c_ready_c   = (state_q == Run) && !full;
  assign c.ready     = c_ready_c;
  assign acc_ready_o = c_ready_c;
  assign push        = c.valid && c_ready_c;
  assign pop         = !empty && out.ready;

  assign out.valid = !empty;
  assign out.data  = mem_q[rd_ptr_q[PtrWidth-1:0]];
  assign busy_o    = (state_q != Idle);
  assign done_o    = done_q;
  assign count_o   = count_q;

`ifdef SNAX_ALU_OUT_PREFIX_SUM_EN
  logic [OutWidth-1:0] acc_q;

  assign wr_data = acc_q + c.data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (start_job) begin
      acc_q <= '0;
    end else if (push) begin
      acc_q <= wr_data;
    end
  end
`else
  assign wr_data = c.data;
`endif

  // Job sequencing.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    start_job = 1'b0;
    unique case (state_q)
      Idle: begin
        if (start_i) begin
          if (num_elem_i != 32'd0) begin
            state_d   = Run;
            start_job = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      Run: begin
        if (push && (count_q == target_q - 32'd1)) state_d = Drain;
      end
      Drain: begin
        if (empty) begin
          state_d = Idle;
          done_d  = 1'b1;
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= Idle;
      done_q   <= 1'b0;
      target_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_job) begin
        target_q <= num_elem_i;
        count_q  <= '0;
      end else if (push) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  // FIFO storage and pointers; reset discards any buffered data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[PtrWidth-1:0]] <= wr_data;
        wr_ptr_q <= wr_ptr_q + CntWidth'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + CntWidth'(1);
    end
  end
endmodule
